regfile_mp: RTL and testbench

//   Parametrised multi-read-port integer register file for the pipelined core.

---
 rtl/regfile_mp.sv | 75 +++++++
 tb/tb_regfile_mp.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with optional write->read bypass and a
// pending-write scoreboard used by ID for hazard stalls.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    input  logic                busy_set,
    input  logic [AW-1:0]       busy_addr,
    output logic [NRD-1:0]      busy
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pending;
    logic [AW-1:0]    ra_w [NRD];

    // Register 0 is hard-wired when ZERO_REG is set, so it is never a legal target.
    function automatic logic addr_valid(input logic [AW-1:0] a);
        return (int'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    for (genvar g = 0; g < NRD; g++) begin : g_ra
        assign ra_w[g] = ra[g*AW +: AW];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the whole array is cleared on reset, so it maps to flops rather than a RAM macro.
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            pending <= '0;
        end else begin
            if (we && addr_valid(wa)) begin
                regs[wa]    <= wd;
                pending[wa] <= 1'b0;
            end
            // NOTE: with non-blocking assignments the last one in program order wins,
            // which is how a same-cycle issue overrides the writeback clear.
            if (busy_set && addr_valid(busy_addr)) begin
                pending[busy_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the block leaves an output unassigned (no latch).
        rd   = '0;
        busy = '0;
        if (rst) begin
            for (int i = 0; i < NRD; i++) begin
                if (addr_valid(ra_w[i])) begin
                    if ((BYPASS != 0) && we && (wa == ra_w[i])) begin
                        rd[i*XLEN +: XLEN] = wd;
                        busy[i]            = 1'b0;
                    end else begin
                        rd[i*XLEN +: XLEN] = regs[ra_w[i]];
                        busy[i]            = pending[ra_w[i]];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two configurations driven in parallel, checked every cycle
// against an array-based reference model, plus directed literal expectations.
module tb_regfile_mp;

    localparam int AW = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [14:0] ra;
    logic        busy_set;
    logic [4:0]  busy_addr;

    // Config A: NREGS=24, NRD=3, BYPASS=1, ZERO_REG=1
    logic [95:0] rd_a;
    logic [2:0]  busy_a;
    // Config B: NREGS=32, NRD=2, BYPASS=0, ZERO_REG=0
    logic [63:0] rd_b;
    logic [1:0]  busy_b;

    regfile_mp #(.XLEN(32), .NREGS(24), .NRD(3), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_a),
        .busy_set(busy_set), .busy_addr(busy_addr), .busy(busy_a)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra[9:0]), .rd(rd_b),
        .busy_set(busy_set), .busy_addr(busy_addr), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference model: architectural register contents and outstanding-producer flags.
    logic [31:0] m_reg  [2][32];
    bit          m_pend [2][32];

    function automatic bit m_valid(input int cfg, input int a);
        if (cfg == 0) return (a < 24) && (a != 0);
        return a < 32;
    endfunction

    function automatic int port_addr(input int i);
        logic [14:0] r;
        r = ra;
        return int'(r[i*AW +: AW]);
    endfunction

    function automatic logic [31:0] m_rd(input int cfg, input int i);
        int a;
        a = port_addr(i);
        if (!rst || !m_valid(cfg, a)) return 32'h0;
        if (cfg == 0 && we && int'(wa) == a) return wd;
        return m_reg[cfg][a];
    endfunction

    function automatic logic m_busy(input int cfg, input int i);
        int a;
        a = port_addr(i);
        if (!rst || !m_valid(cfg, a)) return 1'b0;
        if (cfg == 0 && we && int'(wa) == a) return 1'b0;
        return m_pend[cfg][a];
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (!rst) begin
                for (int r = 0; r < 32; r++) begin
                    m_reg[c][r]  <= 32'h0;
                    m_pend[c][r] <= 1'b0;
                end
            end else begin
                if (we && m_valid(c, int'(wa))) begin
                    m_reg[c][wa]  <= wd;
                    m_pend[c][wa] <= 1'b0;
                end
                if (busy_set && m_valid(c, int'(busy_addr))) m_pend[c][busy_addr] <= 1'b1;
            end
        end
    end

    // Compare process: outputs are combinational, so check mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("rd_a[%0d]", i), rd_a[i*32 +: 32], m_rd(0, i));
                check($sformatf("busy_a[%0d]", i), 32'(busy_a[i]), 32'(m_busy(0, i)));
            end
            for (int i = 0; i < 2; i++) begin
                check($sformatf("rd_b[%0d]", i), rd_b[i*32 +: 32], m_rd(1, i));
                check($sformatf("busy_b[%0d]", i), 32'(busy_b[i]), 32'(m_busy(1, i)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 0; wa = '0; wd = '0; busy_set = 0; busy_addr = '0; ra = '0;
    endtask

    task automatic set_ra(input int p0, input int p1, input int p2);
        ra = {5'(p2), 5'(p1), 5'(p0)};
    endtask

    initial begin
        rst = 1'b0;
        idle();
        tick();
        cmp_en = 1'b1;
        tick();
        rst = 1'b1;

        // Reset sequence: write r5, reset one cycle, read back zero.
        we = 1; wa = 5; wd = 32'hDEADBEEF; tick();
        idle(); set_ra(5, 5, 0); #1;
        check("r5_before_reset", rd_a[31:0], 32'hDEADBEEF);
        tick();
        rst = 1'b0; #1;
        check("rd_forced_in_reset", rd_a[31:0], 32'h0);
        tick();
        rst = 1'b1; #1;
        check("r5_after_reset", rd_a[31:0], 32'h0);
        check("busy_after_reset", 32'(busy_a), 32'h0);
        tick();

        // Register 0: A ignores it; B treats it as an ordinary register.
        we = 1; wa = 0; wd = 32'h1234; busy_set = 1; busy_addr = 0; set_ra(0, 0, 0); #1;
        check("r0_write_cycle", rd_a[31:0], 32'h0);
        check("r0_busy_write_cycle", 32'(busy_a[0]), 32'h0);
        tick();
        idle(); set_ra(0, 0, 0); #1;
        check("r0_after_write", rd_a[31:0], 32'h0);
        check("r0_busy_after", 32'(busy_a[0]), 32'h0);
        check("b_r0_data", rd_b[31:0], 32'h1234);
        check("b_r0_busy", 32'(busy_b[0]), 32'h1);
        tick();

        // Bypass: A forwards wd in the write cycle, B shows the old value.
        we = 1; wa = 7; wd = 32'h11; tick();
        we = 1; wa = 7; wd = 32'h22; set_ra(7, 7, 0); #1;
        check("byp_a0", rd_a[31:0], 32'h22);
        check("byp_a1", rd_a[63:32], 32'h22);
        check("nobyp_b0", rd_b[31:0], 32'h11);
        check("nobyp_b1", rd_b[63:32], 32'h11);
        tick();
        idle(); set_ra(7, 7, 0); #1;
        check("byp_next_a0", rd_a[31:0], 32'h22);
        check("byp_next_b1", rd_b[63:32], 32'h22);
        tick();

        // Scoreboard on r9.
        busy_set = 1; busy_addr = 9; tick();
        idle(); set_ra(0, 9, 0); #1;
        check("sb_set", 32'(busy_a[1]), 32'h1);
        tick();
        we = 1; wa = 9; wd = 32'h99; set_ra(0, 9, 0); #1;
        check("sb_bypass_clear", 32'(busy_a[1]), 32'h0);
        check("sb_b_still_busy", 32'(busy_b[1]), 32'h1);
        tick();
        idle(); set_ra(0, 9, 0); #1;
        check("sb_cleared", 32'(busy_a[1]), 32'h0);
        check("sb_data", rd_a[63:32], 32'h99);
        tick();

        // Set/clear collision on r3: data lands, set wins.
        busy_set = 1; busy_addr = 3; we = 1; wa = 3; wd = 32'h33; tick();
        idle(); set_ra(3, 0, 0); #1;
        check("coll_data", rd_a[31:0], 32'h33);
        check("coll_busy", 32'(busy_a[0]), 32'h1);
        tick();

        // Out of range for A (NREGS=24) but legal for B.
        we = 1; wa = 30; wd = 32'hABCD; busy_set = 1; busy_addr = 30; set_ra(0, 30, 30); #1;
        check("oor_rd2_write_cycle", rd_a[95:64], 32'h0);
        tick();
        idle(); set_ra(0, 30, 30); #1;
        check("oor_rd2", rd_a[95:64], 32'h0);
        check("oor_busy2", 32'(busy_a[2]), 32'h0);
        check("b_r30_data", rd_b[63:32], 32'hABCD);
        tick();

        // Random regression; occasional mid-run resets.
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 99) != 0);
            we        = $urandom_range(0, 1);
            wa        = 5'($urandom_range(0, 31));
            wd        = $urandom;
            busy_set  = ($urandom_range(0, 2) == 0);
            busy_addr = 5'($urandom_range(0, 31));
            ra        = 15'($urandom);
            if ($urandom_range(0, 3) == 0) ra[4:0] = wa;
            if ($urandom_range(0, 3) == 0) ra[9:5] = busy_addr;
            tick();
        end

        rst = 1'b1;
        idle();
        tick();
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
